read_stage: RTL and testbench
=============================

// Module: read_stage
// PURPOSE
//  Pipeline READ stage. Decodes the fetched instruction and reads two operands from the 8-entry register file.
//  Loads the rd2ex pipeline register that feeds EXECUTE and the data-forwarding unit.
//  Consumes that unit's df1/df2/clear/freeze: forwards WB results, inserts bubbles, stalls fetch.
//  Owns the register file write port driven from WRITEBACK.
// PARAMETERS
//  D_SIZE    32  data/register width
//  I_SIZE    16  instruction width; fields [15:9] opcode, [8:6] dest, [5:3] op1, [2:0] op2
//  OPC_SIZE  7   opcode width
// PORTS
//  clk             in   1         clock, all state on rising edge
//  rst             in   1         asynchronous reset, active low
//  instr_in        in   I_SIZE    instruction from fetch
//  instr_valid     in   1         instr_in valid
//  stall_fetch     out  1         fetch must hold instr_in/instr_valid
//  reg_we_wb       in   1         WB register write enable
//  dest_reg_wb     in   3         WB destination register
//  result_wb       in   D_SIZE    WB write data
//  df1, df2        in   1         forward result_wb onto op1/op2 of the instruction in rd2ex
//  clear           in   1         inject bubble into rd2ex
//  freeze          in   1         hold READ input; see BEHAVIOUR
//  valid_rd2ex     out  1         rd2ex holds a real instruction
//  opcode_rd2ex    out  OPC_SIZE  registered opcode
//  dest_rd2ex      out  3         registered destination
//  addr_op1_rd2ex  out  3         registered op1 address
//  addr_op2_rd2ex  out  3         registered op2 address
//  reg_re_en       out  1         equals valid_rd2ex; enables forwarding compare
//  op1_rd2ex       out  D_SIZE    df1 ? result_wb : registered op1 (combinational mux)
//  op2_rd2ex       out  D_SIZE    df2 ? result_wb : registered op2
// BEHAVIOUR
//  Reset (async, rst=0): all rd2ex registers 0, valid_rd2ex=0, all 8 regfile entries 0, stall_fetch=0.
//  Latency: instruction accepted at edge N is visible on rd2ex outputs after edge N; 1 cycle.
//  Regfile write: at the edge when reg_we_wb=1, regs[dest_reg_wb] <= result_wb.
//  Regfile read: combinational on instr_in[5:3] and instr_in[2:0]; sampled into rd2ex at the edge.
//  Per-edge update, in priority order:
//   clear=1, freeze=1 : rd2ex <- bubble (valid=0, opcode=0, addresses 0). stall_fetch=1, so the READ instruction is kept.
//   clear=1 only      : rd2ex <- bubble. stall_fetch=0, so the READ instruction is discarded (flush).
//   freeze=1 only     : rd2ex holds. stall_fetch=1.
//                       If df1/df2 is asserted, the held op1/op2 register loads result_wb, so the forward survives after WB moves on.
//   neither           : rd2ex <- decoded instr_in; valid_rd2ex <- instr_valid.
//  stall_fetch = freeze (combinational).
//  instr_valid=0 with no clear/freeze: a bubble is loaded.
//  Forward muxes apply only while reg_re_en=1. Otherwise the raw registered value is output.
//  Same-cycle WB write to a register being read: see CONFIGURATION.
//  Reset mid-stall: reset wins. Pipeline is empty after release and fetch replays.
//  No arithmetic. All data paths are D_SIZE wide with no truncation.
// CONFIGURATION
//  RF_WRITE_BYPASS_EN defined:
//   If reg_we_wb=1 and dest_reg_wb equals a read address, the read returns result_wb in the same cycle (write-through).
//  Not defined:
//   The read returns the old entry. The new value becomes visible on the next cycle's read.
// STRUCTURE
//  Package rd_pkg holds:
//   - field positions: OPC_MSB/LSB, DEST_MSB/LSB, OP1_MSB/LSB, OP2_MSB/LSB
//   - NOP_OPCODE = 0
//   - REG_NUM = 8
//  Sub-module reg_file:
//   - 8 x D_SIZE entries, async reset
//   - two combinational read ports, one write port
//   - contains the RF_WRITE_BYPASS_EN logic
//  read_stage holds the decode, the rd2ex register, the clear/freeze priority and the forward muxes.
// TESTING
//  1 Reset: rst=0 mid-run -> all outputs 0 immediately; after release, a read of every register returns 0.
//  2 Write then read: write R3=0xDEADBEEF, then instr op1=3 op2=3 -> op1_rd2ex=op2_rd2ex=0xDEADBEEF one cycle later.
//  3 Forward: rd2ex op1=5, drive df1=1, result_wb=0x1234 -> op1_rd2ex=0x1234 in the same cycle.
//    Then freeze=1 with df1=1 for 1 edge, release df1 -> op1_rd2ex stays 0x1234.
//  4 Load-use stall: clear=1, freeze=1 for one edge with instr A on instr_in.
//    -> valid_rd2ex=0 and stall_fetch=1; next edge with both low -> A appears in rd2ex.
//  5 Flush: clear=1 only with instr B -> valid_rd2ex=0, stall_fetch=0, and B never appears in rd2ex.
//  6 Same-cycle write/read of R2, old=0x1, new=0x2:
//    op1_rd2ex=0x2 with RF_WRITE_BYPASS_EN, 0x1 without; run both builds.

Source files
------------

// File: rtl/rd_pkg.sv
// rd_pkg: instruction field positions and register file constants for the READ stage
package rd_pkg;
    localparam int OPC_MSB    = 15;
    localparam int OPC_LSB    = 9;
    localparam int DEST_MSB   = 8;
    localparam int DEST_LSB   = 6;
    localparam int OP1_MSB    = 5;
    localparam int OP1_LSB    = 3;
    localparam int OP2_MSB    = 2;
    localparam int OP2_LSB    = 0;
    localparam int NOP_OPCODE = 0;
    localparam int REG_NUM    = 8;
endpackage

// File: rtl/read_stage_if.sv
// read_stage_if: fetch/writeback/forwarding inputs and rd2ex outputs of the READ stage
interface read_stage_if #(
    parameter int D_SIZE   = 32,
    parameter int I_SIZE   = 16,
    parameter int OPC_SIZE = 7
);
    logic [I_SIZE-1:0]   instr_in;
    logic                instr_valid;
    logic                stall_fetch;
    logic                reg_we_wb;
    logic [2:0]          dest_reg_wb;
    logic [D_SIZE-1:0]   result_wb;
    logic                df1;
    logic                df2;
    logic                clear;
    logic                freeze;
    logic                valid_rd2ex;
    logic [OPC_SIZE-1:0] opcode_rd2ex;
    logic [2:0]          dest_rd2ex;
    logic [2:0]          addr_op1_rd2ex;
    logic [2:0]          addr_op2_rd2ex;
    logic                reg_re_en;
    logic [D_SIZE-1:0]   op1_rd2ex;
    logic [D_SIZE-1:0]   op2_rd2ex;

    modport master (
        output instr_in, instr_valid, reg_we_wb, dest_reg_wb, result_wb, df1, df2, clear, freeze,
        input  stall_fetch, valid_rd2ex, opcode_rd2ex, dest_rd2ex, addr_op1_rd2ex, addr_op2_rd2ex,
               reg_re_en, op1_rd2ex, op2_rd2ex
    );
    modport slave (
        input  instr_in, instr_valid, reg_we_wb, dest_reg_wb, result_wb, df1, df2, clear, freeze,
        output stall_fetch, valid_rd2ex, opcode_rd2ex, dest_rd2ex, addr_op1_rd2ex, addr_op2_rd2ex,
               reg_re_en, op1_rd2ex, op2_rd2ex
    );
endinterface

// File: rtl/read_stage_reg_file.sv
// reg_file: 8-entry register file, two async read ports, one write port; RF_WRITE_BYPASS_EN enables write-through reads
module reg_file
    import rd_pkg::*;
#(
    parameter int D_SIZE = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [2:0]        waddr,
    input  logic [D_SIZE-1:0] wdata,
    input  logic [2:0]        raddr1,
    input  logic [2:0]        raddr2,
    output logic [D_SIZE-1:0] rdata1,
    output logic [D_SIZE-1:0] rdata2
);
    logic [D_SIZE-1:0] regs_q [REG_NUM];
    logic [D_SIZE-1:0] regs_d [REG_NUM];

    // next register contents: writeback lands in the addressed entry
    always_comb begin
        regs_d = regs_q;
        if (we) regs_d[waddr] = wdata;
    end

    // register storage, cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) regs_q <= '{default: '0};
        else      regs_q <= regs_d;
    end

`ifdef RF_WRITE_BYPASS_EN
    assign rdata1 = (we && waddr == raddr1) ? wdata : regs_q[raddr1];
    assign rdata2 = (we && waddr == raddr2) ? wdata : regs_q[raddr2];
`else
    assign rdata1 = regs_q[raddr1];
    assign rdata2 = regs_q[raddr2];
`endif
endmodule

// File: rtl/read_stage.sv
// read_stage: decode, operand read and rd2ex register with clear/freeze control and WB forwarding (RF_WRITE_BYPASS_EN selects regfile write-through)
module read_stage
    import rd_pkg::*;
#(
    parameter int D_SIZE   = 32,
    parameter int I_SIZE   = 16,
    parameter int OPC_SIZE = 7
) (
    input logic         clk,
    input logic         rst,
    read_stage_if.slave bus
);
    logic [I_SIZE-1:0]   instr;
    logic [D_SIZE-1:0]   rdata1, rdata2;
    logic                valid_q, valid_d;
    logic [OPC_SIZE-1:0] opcode_q, opcode_d;
    logic [2:0]          dest_q, dest_d, addr1_q, addr1_d, addr2_q, addr2_d;
    logic [D_SIZE-1:0]   op1_q, op1_d, op2_q, op2_d;
    logic                load;

    assign instr = bus.instr_in;
    assign load  = bus.instr_valid;

    reg_file #(.D_SIZE(D_SIZE)) u_rf (
        .clk   (clk),
        .rst   (rst),
        .we    (bus.reg_we_wb),
        .waddr (bus.dest_reg_wb),
        .wdata (bus.result_wb),
        .raddr1(instr[OP1_MSB:OP1_LSB]),
        .raddr2(instr[OP2_MSB:OP2_LSB]),
        .rdata1(rdata1),
        .rdata2(rdata2)
    );

    // rd2ex next state: clear beats freeze beats a normal (possibly bubble) load
    always_comb begin
        valid_d  = valid_q;
        opcode_d = opcode_q;
        dest_d   = dest_q;
        addr1_d  = addr1_q;
        addr2_d  = addr2_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        if (bus.clear) begin
            valid_d  = 1'b0;
            opcode_d = OPC_SIZE'(NOP_OPCODE);
            dest_d   = '0;
            addr1_d  = '0;
            addr2_d  = '0;
            op1_d    = '0;
            op2_d    = '0;
        end else if (bus.freeze) begin
            op1_d = bus.df1 ? bus.result_wb : op1_q;
            op2_d = bus.df2 ? bus.result_wb : op2_q;
        end else begin
            valid_d  = load;
            opcode_d = load ? instr[OPC_MSB:OPC_LSB] : OPC_SIZE'(NOP_OPCODE);
            dest_d   = load ? instr[DEST_MSB:DEST_LSB] : '0;
            addr1_d  = load ? instr[OP1_MSB:OP1_LSB] : '0;
            addr2_d  = load ? instr[OP2_MSB:OP2_LSB] : '0;
            op1_d    = load ? rdata1 : '0;
            op2_d    = load ? rdata2 : '0;
        end
    end

    // rd2ex pipeline register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            opcode_q <= '0;
            dest_q   <= '0;
            addr1_q  <= '0;
            addr2_q  <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            dest_q   <= dest_d;
            addr1_q  <= addr1_d;
            addr2_q  <= addr2_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
        end
    end

    assign bus.stall_fetch    = bus.freeze & rst;
    assign bus.valid_rd2ex    = valid_q;
    assign bus.reg_re_en      = valid_q;
    assign bus.opcode_rd2ex   = opcode_q;
    assign bus.dest_rd2ex     = dest_q;
    assign bus.addr_op1_rd2ex = addr1_q;
    assign bus.addr_op2_rd2ex = addr2_q;
    assign bus.op1_rd2ex      = (valid_q && bus.df1) ? bus.result_wb : op1_q;
    assign bus.op2_rd2ex      = (valid_q && bus.df2) ? bus.result_wb : op2_q;
endmodule

// File: tb/tb_read_stage.sv
// tb_read_stage: directed test of read_stage against a behavioural pipeline model plus literal expectations
module tb_read_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    read_stage_if #(.D_SIZE(32), .I_SIZE(16), .OPC_SIZE(7)) bus ();
    read_stage #(.D_SIZE(32), .I_SIZE(16), .OPC_SIZE(7)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [6:0]  opc;
        logic [2:0]  d;
        logic [2:0]  a1;
        logic [2:0]  a2;
        logic [31:0] o1;
        logic [31:0] o2;
    } stage_t;

    logic [31:0] mregs [8];
    stage_t      m;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd(input logic [2:0] a);
`ifdef RF_WRITE_BYPASS_EN
        if (bus.reg_we_wb && bus.dest_reg_wb == a) return bus.result_wb;
`endif
        return mregs[a];
    endfunction

    // reference model: register array plus the instruction sitting in rd2ex
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mregs <= '{default: '0};
            m     <= '0;
        end else begin
            if (bus.reg_we_wb) mregs[bus.dest_reg_wb] <= bus.result_wb;
            if (bus.clear) m <= '0;
            else if (bus.freeze) begin
                if (bus.df1) m.o1 <= bus.result_wb;
                if (bus.df2) m.o2 <= bus.result_wb;
            end else if (!bus.instr_valid) m <= '0;
            else m <= {1'b1, bus.instr_in, rd(bus.instr_in[5:3]), rd(bus.instr_in[2:0])};
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        chk("valid", bus.valid_rd2ex, m.v);
        chk("re_en", bus.reg_re_en, m.v);
        chk("opcode", bus.opcode_rd2ex, m.opc);
        chk("dest", bus.dest_rd2ex, m.d);
        chk("addr1", bus.addr_op1_rd2ex, m.a1);
        chk("addr2", bus.addr_op2_rd2ex, m.a2);
        chk("op1", bus.op1_rd2ex, (m.v && bus.df1) ? bus.result_wb : m.o1);
        chk("op2", bus.op2_rd2ex, (m.v && bus.df2) ? bus.result_wb : m.o2);
        chk("stall", bus.stall_fetch, bus.freeze && rst);
    end

    function automatic logic [15:0] enc(input logic [6:0] o, input logic [2:0] d, a, b);
        return {o, d, a, b};
    endfunction

    task automatic drv(input logic [15:0] ins, input logic v, input logic we, input logic [2:0] d,
                       input logic [31:0] r, input logic f1, input logic f2, input logic c, input logic z);
        bus.instr_in    = ins;
        bus.instr_valid = v;
        bus.reg_we_wb   = we;
        bus.dest_reg_wb = d;
        bus.result_wb   = r;
        bus.df1         = f1;
        bus.df2         = f2;
        bus.clear       = c;
        bus.freeze      = z;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drv('0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b1;
        // preload R3, R5, R2
        drv('0, 0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0); step();
        drv('0, 0, 1, 5, 32'h5555, 0, 0, 0, 0); step();
        drv('0, 0, 1, 2, 32'h1, 0, 0, 0, 0); step();
        // write then read R3
        drv(enc(2, 1, 3, 3), 1, 0, 0, 0, 0, 0, 0, 0); step();
        chk("t2_op1", bus.op1_rd2ex, 32'hDEADBEEF);
        chk("t2_op2", bus.op2_rd2ex, 32'hDEADBEEF);
        // forward onto op1, then hold it through a freeze
        drv(enc(3, 4, 5, 0), 1, 0, 0, 0, 0, 0, 0, 0); step();
        chk("t3_raw", bus.op1_rd2ex, 32'h5555);
        drv(enc(1, 1, 1, 1), 1, 0, 0, 32'h1234, 1, 0, 0, 0); #1;
        chk("t3_fwd", bus.op1_rd2ex, 32'h1234);
        drv(enc(1, 1, 1, 1), 1, 0, 0, 32'h1234, 1, 0, 0, 1); step();
        drv(enc(1, 1, 1, 1), 1, 0, 0, 32'h9999, 0, 0, 0, 0); #1;
        chk("t3_held", bus.op1_rd2ex, 32'h1234);
        chk("t3_opc", bus.opcode_rd2ex, 3);
        step();
        // load-use stall: bubble, fetch held, then A loads
        drv(enc(5, 6, 3, 3), 1, 0, 0, 0, 0, 0, 1, 1); step();
        chk("t4_valid", bus.valid_rd2ex, 0);
        chk("t4_stall", bus.stall_fetch, 1);
        drv(enc(5, 6, 3, 3), 1, 0, 0, 0, 0, 0, 0, 0); step();
        chk("t4_A_valid", bus.valid_rd2ex, 1);
        chk("t4_A_opc", bus.opcode_rd2ex, 5);
        chk("t4_A_dest", bus.dest_rd2ex, 6);
        // flush: B discarded
        drv(enc(7'h11, 7, 2, 3), 1, 0, 0, 0, 0, 0, 1, 0); step();
        chk("t5_valid", bus.valid_rd2ex, 0);
        chk("t5_stall", bus.stall_fetch, 0);
        drv(enc(9, 2, 5, 3), 1, 0, 0, 0, 0, 0, 0, 0); step();
        chk("t5_next_opc", bus.opcode_rd2ex, 9);
        // instr_valid low loads a bubble
        drv(enc(7'h22, 1, 1, 1), 0, 0, 0, 0, 0, 0, 0, 0); step();
        chk("bub_valid", bus.valid_rd2ex, 0);
        chk("bub_opc", bus.opcode_rd2ex, 0);
        // same-cycle write/read of R2
        drv(enc(4, 0, 2, 2), 1, 1, 2, 32'h2, 0, 0, 0, 0); step();
`ifdef RF_WRITE_BYPASS_EN
        chk("t6_same", bus.op1_rd2ex, 32'h2);
`else
        chk("t6_same", bus.op1_rd2ex, 32'h1);
`endif
        drv(enc(4, 0, 2, 2), 1, 0, 0, 0, 0, 0, 0, 0); step();
        chk("t6_next", bus.op1_rd2ex, 32'h2);
        // reset mid-stall
        drv(enc(6, 3, 3, 5), 1, 0, 0, 0, 0, 0, 0, 1); step();
        #2 rst = 1'b0;
        #1;
        chk("t1_valid", bus.valid_rd2ex, 0);
        chk("t1_opc", bus.opcode_rd2ex, 0);
        chk("t1_op1", bus.op1_rd2ex, 0);
        chk("t1_stall", bus.stall_fetch, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drv(enc(1, 3'(i), 3'(i), 3'(i + 4)), 1, 0, 0, 0, 0, 0, 0, 0); step();
            chk("t1_rd1", bus.op1_rd2ex, 0);
            chk("t1_rd2", bus.op2_rd2ex, 0);
        end
        drv('0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        @(negedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
